bldc_commutator: RTL and testbench
==================================

Name: bldc_commutator

Overview:
Hall-sensor block-commutation controller for one three-phase BLDC half-bridge set on the motor board. It debounces the three hall inputs and decodes them to a sector (0..5). It drives the six gate signals from a direction-dependent table, inserting a programmable dead time on every commutation. It also flags invalid hall codes and driver faults, and keeps a signed sector-step counter for coarse position.

Parameters:
DEADTIME_CYCLES, 1024, clk cycles with all gates off on every commutation/direction change (>=1)
DEBOUNCE_CYCLES, 1000, consecutive stable cycles required before a hall bit is accepted (>=1)
HALL_INVERT, 3'b000, per-bit XOR applied to hall[2:0] after synchronisation
PHASE_OFFSET, 0, sector rotation (0..5) applied before table lookup
COUNT_W, 32, width of commutation_count

Ports:
clk  in  1  system clock (16 MHz)
reset  in  1  synchronous, active-high reset
hall  in  3  raw hall inputs {h1,h2,h3}, asynchronous
enable  in  1  run request; deassertion also clears FAULT
dir  in  1  1 = forward table, 0 = reverse table
pwm_in  in  1  PWM carrier gating the high-side outputs
fault_n  in  1  gate-driver fault, active low, asynchronous
inh  out  3  high-side gates {C,B,A} = gh & pwm_in
inl  out  3  low-side gates {C,B,A}, registered
sector  out  3  decoded sector, 0..5
sector_valid  out  1  debounced hall code is valid
hall_fault  out  1  sticky: invalid hall code seen while in DRIVE/DEADTIME
sector_skip  out  1  one-cycle pulse on a non-adjacent sector jump
commutation_count  out  COUNT_W  signed sector-step count
deadtime_active  out  1  high while in DEADTIME

Behaviour:
- Reset values: gh/inl = 0, inh = 0, sector = 0, sector_valid = 0, hall_fault = 0, sector_skip = 0, commutation_count = 0, deadtime_active = 0, state = IDLE, debounced halls = 0.
- Input path: hall and fault_n each pass through 2-FF synchronisers. A hall bit updates its debounced value after the synced value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts that bit's counter.
- Decode (registered, +1 cycle), applied to debounced^HALL_INVERT: 101->0, 100->1, 110->2, 010->3, 011->4, 001->5. Codes 000/111 give sector_valid = 0 and sector holds its last value.
- Table index t = (sector + PHASE_OFFSET) mod 6.
  - Forward: 0 HC/LB, 1 HA/LB, 2 HA/LC, 3 HB/LC, 4 HB/LA, 5 HC/LA.
  - Reverse: 0 HB/LC, 1 HB/LA, 2 HC/LA, 3 HC/LB, 4 HA/LB, 5 HA/LC.
  - Exactly one high and one low gate are set, never on the same phase.
- FSM states: IDLE, DEADTIME, DRIVE, FAULT. Gates are 0 in every state except DRIVE.
  - IDLE -> DEADTIME when enable & fault_n(synced) & sector_valid; load dead-time counter.
  - DEADTIME: counts DEADTIME_CYCLES cycles, then -> DRIVE. Gates are 0 for exactly DEADTIME_CYCLES cycles. A sector or dir change during DEADTIME reloads the counter.
  - DRIVE: gates follow table(t, dir). A sector change or dir change -> DEADTIME; gates go 0 on the next clock.
  - Transition priority per cycle, highest first: fault_n low or !sector_valid -> FAULT; !enable -> IDLE; sector/dir change -> DEADTIME.
  - FAULT: gates 0. hall_fault is set if the cause was an invalid hall code. Exit to IDLE only when enable = 0. hall_fault clears on the IDLE->DEADTIME transition or on reset.
- commutation_count updates on every change between two valid sectors, independent of FSM state:
  - new == (old+1) mod 6 -> +1.
  - new == (old+5) mod 6 -> -1.
  - Otherwise unchanged, and sector_skip pulses for 1 cycle.
  - Two's-complement wrap at ±2^(COUNT_W-1).
  - Transitions into or out of an invalid code do not count; the first valid code after an invalid one counts relative to the last valid sector.
- inh is combinational from registered gh and pwm_in; there is no other combinational path from inputs to outputs.
- Reset asserted mid-DRIVE: all gates are 0 on the next clock.

Test Plan:
- DEBOUNCE=4, DEADTIME=8, enable=1, dir=1, hall 101 held -> sector=0 after 2+4+1 cycles; 8 gate-off cycles; then inh=3'b100 (pwm_in=1) and inl=3'b010.
- Step halls 101->100->110->010->011->001->101 -> commutation_count=+6, no sector_skip, 8 gate-off cycles at each step. Reverse sequence -> count returns to 0.
- Hall glitch 101->100 lasting 3 cycles -> no sector change, no dead time, count unchanged.
- In DRIVE, hall goes to 111 -> FAULT, gates 0, hall_fault=1. Hall restored with enable still 1 -> stays FAULT. enable=0 -> IDLE. enable=1 -> hall_fault=0, dead time, then DRIVE.
- In DRIVE at sector 2, toggle dir -> 8 gate-off cycles, then reverse table: inh=3'b100, inl=3'b001. Jump 101->110 -> sector_skip pulses 1 cycle, count unchanged.
- fault_n pulled low mid-DEADTIME -> FAULT within 3 cycles, gates 0, hall_fault stays 0. Reset asserted in DRIVE -> all outputs at reset values on the next clock.

Source files
------------

// File: rtl/bldc_commutator.sv
// Hall-sensor block commutation for one three-phase BLDC bridge.
// The input path is hall/fault synchronisers followed by per-bit hall debounce.
// The debounced code is decoded to a sector, and a small FSM gates the
// six-step table with dead time on every commutation. A signed step counter
// gives coarse position.
module bldc_commutator #(
  parameter int         DEADTIME_CYCLES = 1024,
  parameter int         DEBOUNCE_CYCLES = 1000,
  parameter logic [2:0] HALL_INVERT     = 3'b000,
  parameter int         PHASE_OFFSET    = 0,
  parameter int         COUNT_W         = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         hall,
  input  logic               enable,
  input  logic               dir,
  input  logic               pwm_in,
  input  logic               fault_n,
  output logic [2:0]         inh,
  output logic [2:0]         inl,
  output logic [2:0]         sector,
  output logic               sector_valid,
  output logic               hall_fault,
  output logic               sector_skip,
  output logic [COUNT_W-1:0] commutation_count,
  output logic               deadtime_active
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DT_W = $clog2(DEADTIME_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DEADTIME, DRIVE, FAULT} state_t;

  // ---------------------------------------------------------------------
  // Synchronisers
  // ---------------------------------------------------------------------
  logic [2:0] hall_s1_q, hall_s2_q;
  logic       fault_s1_q, fault_s2_q;

  // Two-flop synchronisers; the fault chain resets to "no fault".
  always_ff @(posedge clk) begin
    if (reset) begin
      hall_s1_q  <= 3'b000;
      hall_s2_q  <= 3'b000;
      fault_s1_q <= 1'b1;
      fault_s2_q <= 1'b1;
    end else begin
      hall_s1_q  <= hall;
      hall_s2_q  <= hall_s1_q;
      fault_s1_q <= fault_n;
      fault_s2_q <= fault_s1_q;
    end
  end

  // ---------------------------------------------------------------------
  // Per-bit debounce
  // ---------------------------------------------------------------------
  logic [2:0] deb_hall;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
      logic            bit_q, bit_d;
      logic [DB_W-1:0] cnt_q, cnt_d;

      // Count consecutive disagreeing cycles; accept on the last one, restart on any bounce.
      always_comb begin
        bit_d = bit_q;
        cnt_d = '0;
        if (hall_s2_q[gi] != bit_q) begin
          if (cnt_q == DB_LAST) begin
            bit_d = hall_s2_q[gi];
          end else begin
            cnt_d = cnt_q + DB_W'(1);
          end
        end
      end

      // Debounce state registers.
      always_ff @(posedge clk) begin
        if (reset) begin
          bit_q <= 1'b0;
          cnt_q <= '0;
        end else begin
          bit_q <= bit_d;
          cnt_q <= cnt_d;
        end
      end

      assign deb_hall[gi] = bit_q;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------
  function automatic logic [2:0] next6(input logic [2:0] s);
    return (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic [2:0] prev6(input logic [2:0] s);
    return (s == 3'd0) ? 3'd5 : s - 3'd1;
  endfunction

  function automatic logic [2:0] rotate(input logic [2:0] s);
    logic [3:0] sum;
    sum = {1'b0, s} + 4'(PHASE_OFFSET % 6);
    if (sum >= 4'd6) sum = sum - 4'd6;
    return sum[2:0];
  endfunction

  // Returns {high_side, low_side}, each {C,B,A}.
  function automatic logic [5:0] gate_table(input logic [2:0] t, input logic fwd);
    logic [5:0] g;
    g = 6'b000000;
    if (fwd) begin
      case (t)
        3'd0:    g = {3'b100, 3'b010};
        3'd1:    g = {3'b001, 3'b010};
        3'd2:    g = {3'b001, 3'b100};
        3'd3:    g = {3'b010, 3'b100};
        3'd4:    g = {3'b010, 3'b001};
        3'd5:    g = {3'b100, 3'b001};
        default: g = 6'b000000;
      endcase
    end else begin
      case (t)
        3'd0:    g = {3'b010, 3'b100};
        3'd1:    g = {3'b010, 3'b001};
        3'd2:    g = {3'b100, 3'b001};
        3'd3:    g = {3'b100, 3'b010};
        3'd4:    g = {3'b001, 3'b010};
        3'd5:    g = {3'b001, 3'b100};
        default: g = 6'b000000;
      endcase
    end
    return g;
  endfunction

  // ---------------------------------------------------------------------
  // Decode and step counter
  // ---------------------------------------------------------------------
  logic [2:0]         code;
  logic [2:0]         dec_sector;
  logic               dec_valid;
  logic [2:0]         sector_q, sector_d;
  logic               sector_valid_q, sector_valid_d;
  logic               seen_valid_q, seen_valid_d;
  logic               skip_q, skip_d;
  logic [COUNT_W-1:0] count_q, count_d;

  // Hall code to sector map; 000/111 are invalid.
  always_comb begin
    code       = deb_hall ^ HALL_INVERT;
    dec_sector = 3'd0;
    dec_valid  = 1'b1;
    case (code)
      3'b101:  dec_sector = 3'd0;
      3'b100:  dec_sector = 3'd1;
      3'b110:  dec_sector = 3'd2;
      3'b010:  dec_sector = 3'd3;
      3'b011:  dec_sector = 3'd4;
      3'b001:  dec_sector = 3'd5;
      default: dec_valid  = 1'b0;
    endcase
  end

  // Sector holds through invalid codes, so it is always the last valid one.
  // The very first valid code after reset has no predecessor and is not counted.
  always_comb begin
    sector_d       = dec_valid ? dec_sector : sector_q;
    sector_valid_d = dec_valid;
    seen_valid_d   = seen_valid_q | dec_valid;
    skip_d         = 1'b0;
    count_d        = count_q;
    if (dec_valid && seen_valid_q && (dec_sector != sector_q)) begin
      if (dec_sector == next6(sector_q)) begin
        count_d = count_q + COUNT_W'(1);
      end else if (dec_sector == prev6(sector_q)) begin
        count_d = count_q - COUNT_W'(1);
      end else begin
        skip_d = 1'b1;
      end
    end
  end

  // Decode/counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sector_q       <= 3'd0;
      sector_valid_q <= 1'b0;
      seen_valid_q   <= 1'b0;
      skip_q         <= 1'b0;
      count_q        <= '0;
    end else begin
      sector_q       <= sector_d;
      sector_valid_q <= sector_valid_d;
      seen_valid_q   <= seen_valid_d;
      skip_q         <= skip_d;
      count_q        <= count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Commutation FSM
  // ---------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
  logic [2:0]      last_sector_q;
  logic            last_dir_q;
  logic            hall_fault_q, hall_fault_d;
  logic [2:0]      gh_q, gl_q;
  logic [2:0]      gh_d, gl_d;
  logic            change;
  logic            bad;

  // Next state; gates come from the next state so they drop on the same edge as DRIVE is left.
  always_comb begin
    state_d      = state_q;
    dt_cnt_d     = dt_cnt_q;
    hall_fault_d = hall_fault_q;
    change       = (sector_q != last_sector_q) || (dir != last_dir_q);
    bad          = !fault_s2_q || !sector_valid_q;
    case (state_q)
      IDLE: begin
        if (enable && fault_s2_q && sector_valid_q) begin
          state_d      = DEADTIME;
          dt_cnt_d     = DT_LOAD;
          hall_fault_d = 1'b0;
        end
      end
      DEADTIME: begin
        if (bad) begin
          state_d      = FAULT;
          hall_fault_d = hall_fault_q | !sector_valid_q;
        end else if (!enable) begin
          state_d = IDLE;
        end else if (change) begin
          dt_cnt_d = DT_LOAD;
        end else if (dt_cnt_q == '0) begin
          state_d = DRIVE;
        end else begin
          dt_cnt_d = dt_cnt_q - DT_W'(1);
        end
      end
      DRIVE: begin
        if (bad) begin
          state_d      = FAULT;
          hall_fault_d = hall_fault_q | !sector_valid_q;
        end else if (!enable) begin
          state_d = IDLE;
        end else if (change) begin
          state_d  = DEADTIME;
          dt_cnt_d = DT_LOAD;
        end
      end
      FAULT: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    gh_d = 3'b000;
    gl_d = 3'b000;
    if (state_d == DRIVE) begin
      {gh_d, gl_d} = gate_table(rotate(sector_q), dir);
    end
  end

  // FSM, change-detect and gate registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      dt_cnt_q      <= '0;
      last_sector_q <= 3'd0;
      last_dir_q    <= 1'b0;
      hall_fault_q  <= 1'b0;
      gh_q          <= 3'b000;
      gl_q          <= 3'b000;
    end else begin
      state_q       <= state_d;
      dt_cnt_q      <= dt_cnt_d;
      last_sector_q <= sector_q;
      last_dir_q    <= dir;
      hall_fault_q  <= hall_fault_d;
      gh_q          <= gh_d;
      gl_q          <= gl_d;
    end
  end

  assign inh               = gh_q & {3{pwm_in}};
  assign inl               = gl_q;
  assign sector            = sector_q;
  assign sector_valid      = sector_valid_q;
  assign hall_fault        = hall_fault_q;
  assign sector_skip       = skip_q;
  assign commutation_count = count_q;
  assign deadtime_active   = (state_q == DEADTIME);

endmodule

// File: tb/tb_bldc_commutator.sv
// Directed bench for bldc_commutator with short debounce and dead time.
module tb_bldc_commutator;

  localparam int DT = 8;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  hall;
  logic        enable, dir, pwm_in, fault_n;
  logic [2:0]  inh, inl, sector;
  logic        sector_valid, hall_fault, sector_skip, deadtime_active;
  logic [15:0] commutation_count;

  int passed = 0;
  int total  = 0;
  int skip_cnt = 0;

  // Expected gate patterns {C,B,A} per sector.
  logic [2:0] fwd_h [6] = '{3'b100, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100};
  logic [2:0] fwd_l [6] = '{3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
  logic [2:0] rev_h [6] = '{3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
  logic [2:0] rev_l [6] = '{3'b100, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100};

  bldc_commutator #(
    .DEADTIME_CYCLES(DT),
    .DEBOUNCE_CYCLES(DB),
    .HALL_INVERT(3'b000),
    .PHASE_OFFSET(0),
    .COUNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .hall(hall), .enable(enable), .dir(dir),
    .pwm_in(pwm_in), .fault_n(fault_n), .inh(inh), .inl(inl),
    .sector(sector), .sector_valid(sector_valid), .hall_fault(hall_fault),
    .sector_skip(sector_skip), .commutation_count(commutation_count),
    .deadtime_active(deadtime_active)
  );

  always #5 clk = ~clk;

  // Cycles during which sector_skip is high.
  always @(posedge clk) if (sector_skip) skip_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Wait for dead time, count its gate-off length, then check drive gates.
  task automatic commutate(input string tag, input int exp_sec, input logic fwd);
    int  n;
    int  off;
    bit  leak;
    n = 0;
    while (!deadtime_active && n < 60) begin tick(); n++; end
    check({tag, "_dt_start"}, (n < 60), 1);
    off  = 0;
    leak = 0;
    while (deadtime_active && off < 100) begin
      if (inh != 3'b000 || inl != 3'b000) leak = 1;
      off++;
      tick();
    end
    check({tag, "_dt_len"}, off, DT);
    check({tag, "_dt_gates_off"}, leak, 0);
    check({tag, "_sector"}, sector, exp_sec);
    check({tag, "_inh"}, inh, fwd ? fwd_h[exp_sec] : rev_h[exp_sec]);
    check({tag, "_inl"}, inl, fwd ? fwd_l[exp_sec] : rev_l[exp_sec]);
    $display("step %s: sector=%0d inh=%b inl=%b dt=%0d count=%0d", tag, sector, inh, inl, off, $signed(commutation_count));
  endtask

  initial begin
    int n;
    bit seen;
    logic [2:0] fwd_seq [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    logic [2:0] rev_seq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
    int fwd_sec [6] = '{1, 2, 3, 4, 5, 0};
    int rev_sec [6] = '{5, 4, 3, 2, 1, 0};

    reset = 1'b1; hall = 3'b000; enable = 1'b0; dir = 1'b1; pwm_in = 1'b1; fault_n = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_inh", inh, 0);
    check("rst_inl", inl, 0);
    check("rst_sector", sector, 0);
    check("rst_valid", sector_valid, 0);
    check("rst_hall_fault", hall_fault, 0);
    check("rst_count", commutation_count, 0);
    check("rst_dt", deadtime_active, 0);

    // Startup: 2 sync + 4 debounce + 1 decode cycles.
    hall = 3'b101; enable = 1'b1;
    n = 0;
    while (!sector_valid && n < 50) begin tick(); n++; end
    check("startup_latency", n, 7);
    commutate("start", 0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      hall = fwd_seq[i];
      commutate($sformatf("fwd%0d", i), fwd_sec[i], 1'b1);
    end
    check("fwd_count", commutation_count, 6);
    check("fwd_no_skip", skip_cnt, 0);

    for (int i = 0; i < 6; i++) begin
      hall = rev_seq[i];
      commutate($sformatf("rev%0d", i), rev_sec[i], 1'b1);
    end
    check("rev_count", commutation_count, 0);

    // Three-cycle glitch must be rejected.
    hall = 3'b100;
    repeat (3) tick();
    hall = 3'b101;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (deadtime_active) seen = 1;
    end
    check("glitch_no_dt", seen, 0);
    check("glitch_sector", sector, 0);
    check("glitch_count", commutation_count, 0);
    check("glitch_inh", inh, 3'b100);
    $display("glitch: sector=%0d count=%0d", sector, $signed(commutation_count));

    // Invalid hall code in DRIVE.
    hall = 3'b111;
    n = 0;
    while (inl != 3'b000 && n < 40) begin tick(); n++; end
    tick();
    check("inv_gates_l", inl, 0);
    check("inv_gates_h", inh, 0);
    check("inv_hall_fault", hall_fault, 1);
    check("inv_valid", sector_valid, 0);
    hall = 3'b101;
    repeat (20) tick();
    check("inv_stay_fault_l", inl, 0);
    check("inv_stay_fault_dt", deadtime_active, 0);
    check("inv_stay_hall_fault", hall_fault, 1);
    enable = 1'b0;
    repeat (2) tick();
    check("idle_hall_fault", hall_fault, 1);
    enable = 1'b1;
    commutate("refire", 0, 1'b1);
    check("refire_hall_fault", hall_fault, 0);
    check("refire_count", commutation_count, 0);

    // Move to sector 2, then reverse direction.
    hall = 3'b100;
    commutate("to1", 1, 1'b1);
    hall = 3'b110;
    commutate("to2", 2, 1'b1);
    dir = 1'b0;
    commutate("dir_rev", 2, 1'b0);
    check("dir_count", commutation_count, 2);

    // Non-adjacent jump 2 -> 0.
    hall = 3'b101;
    commutate("skip", 0, 1'b0);
    check("skip_pulse", skip_cnt, 1);
    check("skip_count", commutation_count, 2);

    // Driver fault during dead time.
    hall = 3'b100;
    n = 0;
    while (!deadtime_active && n < 60) begin tick(); n++; end
    tick(); tick();
    check("dt_before_fault", deadtime_active, 1);
    fault_n = 1'b0;
    n = 0;
    while (deadtime_active && n < 10) begin tick(); n++; end
    check("fault_latency", (n >= 1 && n <= 3), 1);
    repeat (5) tick();
    check("fault_dt", deadtime_active, 0);
    check("fault_inh", inh, 0);
    check("fault_inl", inl, 0);
    check("fault_hall_fault", hall_fault, 0);
    check("fault_count", commutation_count, 3);
    fault_n = 1'b1;
    enable  = 1'b0;
    repeat (4) tick();
    enable  = 1'b1;
    commutate("recover", 1, 1'b0);

    // Reset in DRIVE.
    reset = 1'b1;
    tick();
    check("rst2_inh", inh, 0);
    check("rst2_inl", inl, 0);
    check("rst2_sector", sector, 0);
    check("rst2_valid", sector_valid, 0);
    check("rst2_count", commutation_count, 0);
    check("rst2_dt", deadtime_active, 0);
    check("rst2_hall_fault", hall_fault, 0);
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
